seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, iterative shift-add multiplier with valid/ready handshakes, signed/unsigned mode and an N-bit overflow flag. It is the multi-cycle successor to the combinational array multiplier. It trades N+1 cycles of latency for one adder's worth of logic, so wide ALU datapaths (N=16 and up) close timing on the FPGA. It sits behind the ALU opcode decoder and is shared by the MUL/MULU operations.

## Interface
- `N`, 16, operand width; legal range 2..32.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and mode presented.
- `in_ready` output 1: block can accept an operation.
- `is_signed` input 1: 1 = two's-complement operands, 0 = unsigned; sampled with operands.
- `a` input N: multiplicand.
- `b` input N: multiplier.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: consumer accepts the result.
- `p` output 2N: full-width product.
- `overflow` output 1: product does not fit in N bits for the captured mode.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: N iterations.
  - SIGN: apply the sign and compute `overflow`.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid && in_ready`. The accept captures the following:
  - `is_signed`, and sign = a[N-1]^b[N-1] when signed (else 0).
  - |a| and |b| as N-bit magnitudes. Signed −2^(N-1) gives magnitude 2^(N-1), which fits in N bits unsigned.
  - Clears the 2N-bit accumulator and the iteration counter.
- RUN, each cycle:
  - If the multiplier LSB is 1, the accumulator upper half gets upper half + multiplicand magnitude, with carry kept (N+1-bit add).
  - Then the {carry, accumulator} pair shifts right 1 and the counter increments.
  - After N iterations, go to SIGN.
- SIGN:
  - `p` = sign ? −acc : acc, computed modulo 2^(2N).
  - `overflow`, unsigned mode: |p[2N-1:N].
  - `overflow`, signed mode: p[2N-1:N] ≠ {N{p[N-1]}}.
  - Go to DONE.
- DONE→IDLE on `out_ready`. `p` and `overflow` stay stable while `out_valid`=1 and `out_ready`=0.
- There is no overlap between operations. In_valid outside IDLE is ignored, since `in_ready`=0.
- A zero operand follows the normal path; there is no early exit, so latency is constant.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `p`=0.
  - `overflow`=0.
  - Accumulator and counter cleared.
- Reset is asynchronous and may arrive in any state, including mid-RUN. The operation is discarded and no `out_valid` pulse is produced.
- Cycle numbering: accept at rising edge k.
  - Edges k+1..k+N perform the N iterations.
  - Edge k+N+1 registers `p`/`overflow` and raises `out_valid`.
  - Latency is N+1 cycles from accept edge to `out_valid`.
- `out_valid` drops on the edge where `out_valid && out_ready`. `in_ready` rises on that same edge.
- Best-case throughput: one operation per N+3 cycles.
- `in_ready` and `out_valid` are pure state decodes, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `seq_mult_pkg` holds:
  - the state enum (IDLE, RUN, SIGN, DONE);
  - a `CNT_W` function, $clog2(N+1);
  - the overflow-check function (product, mode → flag), shared with the ALU flag logic.
- One sub-module, `seq_mult_datapath`, contains the following:
  - the magnitude conversion, the accumulator/shift register and the final negation;
  - the control is a load/step/finish strobe interface.
- The top module holds the FSM, the counter and the handshakes.

## Test plan
- N=8, unsigned, a=12, b=10 → `p`=0x0078, `overflow`=0. `out_valid` appears exactly 9 cycles after accept.
- N=8, unsigned, a=255, b=255 → `p`=0xFE01, `overflow`=1.
- N=8, signed:
  - a=0xFD (−3), b=5 → `p`=0xFFF1, `overflow`=0.
  - a=0x80, b=0x80 → `p`=0x4000, `overflow`=1.
- N=16, signed, a=0x8000, b=1 → `p`=0xFFFF8000, `overflow`=0. Same operands with b=0xFFFF → `p`=0x00008000, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `p` and `overflow` stable, and `in_ready`=0 throughout. Toggle `in_valid` with new operands during the hold → result unchanged.
- Assert `rst` at RUN iteration 3 → all outputs at reset values immediately, no `out_valid`. The next operation, a=7 and b=6 unsigned, gives `p`=42.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the iterative shift-add multiplier:
//   - state_e   : FSM state encoding (IDLE, RUN, SIGN, DONE)
//   - CNT_W     : iteration counter width for an N-bit operand
//   - ovf_check : N-bit overflow flag of a 2N-bit product (also used by the
//                 ALU flag logic, hence width-generic up to N=32)
// ---------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter must be able to hold the value N itself.
    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

    // prod holds a 2n-bit product in its low bits (n <= 32).
    // Unsigned: any bit set in the upper half means it does not fit.
    // Signed:   the upper half must be a pure sign extension of bit n-1.
    function automatic logic ovf_check(input logic [63:0] prod,
                                       input int unsigned n,
                                       input logic signed_mode);
        logic [63:0] full_mask;
        logic [63:0] low_mask;
        logic [63:0] hi_mask;
        logic [63:0] msb_shift;
        logic [63:0] ext;
        // For n=32, 1<<64 wraps to 0 and 0-1 gives all ones, as wanted.
        full_mask = (64'd1 << (2 * n)) - 64'd1;
        low_mask  = (64'd1 << n) - 64'd1;
        hi_mask   = full_mask & ~low_mask;
        msb_shift = prod >> (n - 1);
        ext       = (signed_mode && msb_shift[0]) ? hi_mask : 64'd0;
        if (signed_mode)
            return |((prod ^ ext) & hi_mask);
        else
            return |(prod & hi_mask);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Request/response handshake bundle of the sequential multiplier.
//   request : in_valid, in_ready, is_signed, a, b
//   response: out_valid, out_ready, p, overflow
// master = client issuing operations, slave = the multiplier.
// ---------------------------------------------------------------------------
interface seq_multiplier_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;
    logic           overflow;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, p, overflow
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, p, overflow
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// ---------------------------------------------------------------------------
// seq_mult_datapath
// Magnitude conversion, shift-add accumulator and final sign application.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture operands/mode, clear accumulator
//   step      : one shift-add iteration
//   finish    : register signed product and overflow flag
//   is_signed : operand mode (sampled on load)
//   a, b      : multiplicand, multiplier
//   p         : 2N-bit product (held between finish strobes)
//   overflow  : product does not fit in N bits for the captured mode
// ---------------------------------------------------------------------------
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           finish,
    input  logic           is_signed,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p,
    output logic           overflow
);

    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic           sign;
    logic           mode;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     sum;
    logic [2*N-1:0] p_next;
    logic [63:0]    p_ext;

    always_comb begin
        // -2^(N-1) maps onto itself, which is the correct unsigned magnitude.
        a_mag  = (is_signed && a[N-1]) ? (~a + 1'b1) : a;
        b_mag  = (is_signed && b[N-1]) ? (~b + 1'b1) : b;
        // Upper half plus multiplicand, carry kept in bit N.
        sum    = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        p_next = sign ? (~acc + 1'b1) : acc;
        p_ext  = 64'd0;
        p_ext[2*N-1:0] = p_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            mode     <= 1'b0;
            p        <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            sign   <= is_signed & (a[N-1] ^ b[N-1]);
            mode   <= is_signed;
        end else if (step) begin
            // {carry, upper, lower} shifted right by one.
            acc    <= {sum, acc[N-1:1]};
            mplier <= mplier >> 1;
        end else if (finish) begin
            p        <= p_next;
            overflow <= ovf_check(p_ext, N, mode);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, N+1 cycles from accept to result.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (discards any operation in flight)
//   bus  : seq_multiplier_if.slave
//          in_valid/in_ready   operand handshake (in_ready only in IDLE)
//          is_signed, a, b     mode and operands
//          out_valid/out_ready result handshake (out_valid only in DONE)
//          p, overflow         product and N-bit overflow flag
// in_ready/out_valid are pure state decodes.
// ---------------------------------------------------------------------------
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_multiplier_if.slave bus
);

    localparam int CW = CNT_W(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_SIGN = SIGN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          finish;

    assign load   = (state == ST_IDLE) && bus.in_valid;
    assign step   = (state == ST_RUN);
    assign finish = (state == ST_SIGN);

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= ST_SIGN;
                end
                ST_SIGN: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    seq_mult_datapath #(.N(N)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .is_signed (bus.is_signed),
        .a         (bus.a),
        .b         (bus.b),
        .p         (bus.p),
        .overflow  (bus.overflow)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed bench for seq_multiplier at N=8 and N=16: a vector table of
// hand-computed products, then backpressure and mid-operation reset cases.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_multiplier_if #(.N(8))  bus8 ();
    seq_multiplier_if #(.N(16)) bus16 ();

    seq_multiplier #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    seq_multiplier #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          n;
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic        ovf;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic sm,
                         input logic [31:0] a, input logic [31:0] b);
        if (n == 8) begin
            bus8.in_valid = v; bus8.is_signed = sm; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus16.in_valid = v; bus16.is_signed = sm; bus16.a = a[15:0]; bus16.b = b[15:0];
        end
    endtask

    task automatic set_oready(input int n, input logic r);
        if (n == 8) bus8.out_ready = r;
        else        bus16.out_ready = r;
    endtask

    function automatic logic get_ov(input int n);
        return (n == 8) ? bus8.out_valid : bus16.out_valid;
    endfunction

    function automatic logic get_ir(input int n);
        return (n == 8) ? bus8.in_ready : bus16.in_ready;
    endfunction

    function automatic logic [63:0] get_p(input int n);
        logic [63:0] r;
        r = 64'd0;
        if (n == 8) r[15:0] = bus8.p;
        else        r[31:0] = bus16.p;
        return r;
    endfunction

    function automatic logic get_ovf(input int n);
        return (n == 8) ? bus8.overflow : bus16.overflow;
    endfunction

    // Issue one operation, wait (bounded) for the result, then accept it.
    task automatic do_op(input int n, input logic sm, input logic [31:0] a,
                         input logic [31:0] b, output logic [63:0] p,
                         output logic ovf, output int lat);
        @(negedge clk);
        drive(n, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!get_ov(n) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p   = get_p(n);
        ovf = get_ovf(n);
        set_oready(n, 1'b1);
        @(posedge clk); #1;
        set_oready(n, 1'b0);
    endtask

    initial begin
        logic [63:0] p;
        logic        ovf;
        int          lat;
        int          seen;

        vecs[0]  = '{8,  1'b0, 32'd12,   32'd10,   64'h0078,     1'b0};
        vecs[1]  = '{8,  1'b0, 32'd255,  32'd255,  64'hFE01,     1'b1};
        vecs[2]  = '{8,  1'b1, 32'hFD,   32'd5,    64'hFFF1,     1'b0};
        vecs[3]  = '{8,  1'b1, 32'h80,   32'h80,   64'h4000,     1'b1};
        vecs[4]  = '{8,  1'b0, 32'd0,    32'd200,  64'h0000,     1'b0};
        vecs[5]  = '{8,  1'b0, 32'd16,   32'd16,   64'h0100,     1'b1};
        vecs[6]  = '{8,  1'b0, 32'd15,   32'd17,   64'h00FF,     1'b0};
        vecs[7]  = '{8,  1'b1, 32'h80,   32'h01,   64'hFF80,     1'b0};
        vecs[8]  = '{8,  1'b1, 32'hFF,   32'hFF,   64'h0001,     1'b0};
        vecs[9]  = '{8,  1'b1, 32'h7F,   32'h7F,   64'h3F01,     1'b1};
        vecs[10] = '{8,  1'b1, 32'h80,   32'hFF,   64'h0080,     1'b1};
        vecs[11] = '{8,  1'b1, 32'hF0,   32'h08,   64'hFF80,     1'b0};
        vecs[12] = '{16, 1'b1, 32'h8000, 32'h0001, 64'hFFFF8000, 1'b0};
        vecs[13] = '{16, 1'b1, 32'h8000, 32'hFFFF, 64'h00008000, 1'b1};
        vecs[14] = '{16, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 1'b1};
        vecs[15] = '{16, 1'b1, 32'h1234, 32'h0000, 64'h00000000, 1'b0};

        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(16, 1'b0, 1'b0, 32'd0, 32'd0);
        set_oready(8, 1'b0);
        set_oready(16, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready8",   64'(bus8.in_ready),  64'd1);
        check("rst_out_valid8",  64'(bus8.out_valid), 64'd0);
        check("rst_p8",          64'(bus8.p),         64'd0);
        check("rst_overflow8",   64'(bus8.overflow),  64'd0);
        check("rst_in_ready16",  64'(bus16.in_ready), 64'd1);
        check("rst_out_valid16", 64'(bus16.out_valid),64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].n, vecs[i].sm, vecs[i].a, vecs[i].b, p, ovf, lat);
            check($sformatf("vec%0d_p", i),   p,          vecs[i].p);
            check($sformatf("vec%0d_ovf", i), 64'(ovf),   64'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 64'(lat),   64'(vecs[i].n + 1));
            check($sformatf("vec%0d_idle", i), 64'(get_ir(vecs[i].n)), 64'd1);
        end

        // Backpressure: result held while out_ready is low, new requests ignored
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 32'd12, 32'd10);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd9);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_p_c%0d", c),        64'(bus8.p),         64'h0078);
            check($sformatf("bp_ovf_c%0d", c),      64'(bus8.overflow),  64'd0);
            check($sformatf("bp_in_ready_c%0d", c), 64'(bus8.in_ready),  64'd0);
            check($sformatf("bp_out_valid_c%0d", c),64'(bus8.out_valid), 64'd1);
            drive(8, ~bus8.in_valid, 1'b1, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
            @(posedge clk); #1;
        end
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        check("bp_p_final", 64'(bus8.p), 64'h0078);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("bp_in_ready_after",  64'(bus8.in_ready),  64'd1);
        check("bp_out_valid_after", 64'(bus8.out_valid), 64'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen++;
        end
        check("bp_no_ghost_op", 64'(seen), 64'd0);

        // Asynchronous reset during RUN iteration 3
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 32'd200, 32'd3);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  64'(bus8.in_ready),  64'd1);
        check("arst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("arst_p",         64'(bus8.p),         64'd0);
        check("arst_overflow",  64'(bus8.overflow),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen++;
        end
        check("arst_no_out_valid", 64'(seen), 64'd0);
        do_op(8, 1'b0, 32'd7, 32'd6, p, ovf, lat);
        check("post_rst_p",   p,          64'd42);
        check("post_rst_ovf", 64'(ovf),   64'd0);
        check("post_rst_lat", 64'(lat),   64'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
